// File: rtl/vga_timing_fetch_pkg.sv
// Shared 720p raster constants and the record carried down the alignment pipe.
package vga_timing_fetch_pkg;

  localparam int IMAGE_WIDTH   = 1280;
  localparam int HFP_WIDTH     = 110;
  localparam int HSYNCH_WIDTH  = 40;
  localparam int HBP_WIDTH     = 220;
  localparam int IMAGE_HEIGHT  = 720;
  localparam int VFP_HEIGHT    = 5;
  localparam int VSYNCH_HEIGHT = 5;
  localparam int VBP_HEIGHT    = 20;
  localparam int ADDR_W        = 18;
  localparam int RD_LATENCY    = 2;

  localparam int H_TOTAL  = IMAGE_WIDTH + HFP_WIDTH + HSYNCH_WIDTH + HBP_WIDTH;
  localparam int V_TOTAL  = IMAGE_HEIGHT + VFP_HEIGHT + VSYNCH_HEIGHT + VBP_HEIGHT;
  localparam int HALF_W   = IMAGE_WIDTH / 2;

  localparam int H_W = 11;
  localparam int V_W = 10;

  // One raster sample as it travels toward pixelgen.
  typedef struct packed {
    logic           frame;
    logic           act;
    logic [V_W-1:0] v;
    logic [H_W-1:0] h;
  } raster_t;

endpackage

// File: rtl/vga_timing_fetch_delay_pipe.sv
// Fixed-depth shift register with async clear; used to line raster state up
// with frame-buffer read data.
module vga_timing_fetch_delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  // Shift every clock; all stages clear together on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_fetch.sv
// 720p raster counters plus 2x-upscaled frame-buffer fetch. Position/valid are
// delayed so they reach pixelgen in the same cycle as the fetched word.
module vga_timing_fetch
  import vga_timing_fetch_pkg::*;
#(
  parameter int P_IMAGE_WIDTH   = IMAGE_WIDTH,
  parameter int P_HFP_WIDTH     = HFP_WIDTH,
  parameter int P_HSYNCH_WIDTH  = HSYNCH_WIDTH,
  parameter int P_HBP_WIDTH     = HBP_WIDTH,
  parameter int P_IMAGE_HEIGHT  = IMAGE_HEIGHT,
  parameter int P_VFP_HEIGHT    = VFP_HEIGHT,
  parameter int P_VSYNCH_HEIGHT = VSYNCH_HEIGHT,
  parameter int P_VBP_HEIGHT    = VBP_HEIGHT,
  parameter int P_ADDR_W        = ADDR_W,
  parameter int P_RD_LATENCY    = RD_LATENCY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic [P_ADDR_W-1:0] rd_addr,
  output logic                rd_en,
  output logic [31:0]         H_pos,
  output logic [31:0]         V_pos,
  output logic                valid_video,
  output logic                frame_start
);

  localparam int HT    = P_IMAGE_WIDTH + P_HFP_WIDTH + P_HSYNCH_WIDTH + P_HBP_WIDTH;
  localparam int VT    = P_IMAGE_HEIGHT + P_VFP_HEIGHT + P_VSYNCH_HEIGHT + P_VBP_HEIGHT;
  localparam int HW2   = P_IMAGE_WIDTH / 2;
  localparam int DEPTH = 1 + P_RD_LATENCY;

  logic [H_W-1:0]      h_cnt;
  logic [V_W-1:0]      v_cnt;
  logic [P_ADDR_W-1:0] line_base;
  logic                h_last, v_last, act, frame_flag;
  raster_t             pipe_in, pipe_out;

  assign h_last     = (h_cnt == H_W'(HT - 1));
  assign v_last     = (v_cnt == V_W'(VT - 1));
  assign act        = (h_cnt < H_W'(P_IMAGE_WIDTH)) && (v_cnt < V_W'(P_IMAGE_HEIGHT)) && enable;
  assign frame_flag = (h_cnt == '0) && (v_cnt == '0) && enable;

  // Raster counters and per-line-pair base address; all hold while disabled.
  // line_base steps after each odd active line so source rows repeat twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      line_base <= '0;
    end else if (enable) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt     <= '0;
          line_base <= '0;
        end else begin
          v_cnt <= v_cnt + 1'b1;
          if (v_cnt[0] && (v_cnt < V_W'(P_IMAGE_HEIGHT)))
            line_base <= line_base + P_ADDR_W'(HW2);
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Fetch address: column halved for horizontal 2x; zero outside active area.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      rd_en   <= 1'b0;
    end else begin
      rd_addr <= act ? line_base + P_ADDR_W'(h_cnt[H_W-1:1]) : '0;
      rd_en   <= act;
    end
  end

  assign pipe_in = {frame_flag, act, v_cnt, h_cnt};

  vga_timing_fetch_delay_pipe #(
    .WIDTH ($bits(raster_t)),
    .DEPTH (DEPTH)
  ) u_align (
    .clk   (clk),
    .reset (reset),
    .d     (pipe_in),
    .q     (pipe_out)
  );

  assign H_pos       = 32'(pipe_out.h);
  assign V_pos       = 32'(pipe_out.v);
  assign valid_video = pipe_out.act;
  assign frame_start = pipe_out.frame;

endmodule

// File: tb/tb_vga_timing_fetch.sv
// Randomized bench: full 720p instance plus a tiny-geometry instance so frame
// wraps are exercised many times. Reference is a position/latency model.
module tb_vga_timing_fetch;
  import vga_timing_fetch_pkg::*;

  localparam int D = 1 + RD_LATENCY;
  localparam int SIW = 16, SHFP = 3, SHS = 2, SHBP = 4;
  localparam int SIH = 8,  SVFP = 1, SVS = 1, SVBP = 2;
  localparam int N_CYC = 45000;

  logic clk = 1'b0;
  logic reset, en_f, en_s;
  logic [ADDR_W-1:0] addr_f, addr_s;
  logic ren_f, ren_s, vv_f, vv_s, fs_f, fs_s;
  logic [31:0] hp_f, vp_f, hp_s, vp_s;

  always #5 clk = ~clk;

  vga_timing_fetch u_full (
    .clk(clk), .reset(reset), .enable(en_f), .rd_addr(addr_f), .rd_en(ren_f),
    .H_pos(hp_f), .V_pos(vp_f), .valid_video(vv_f), .frame_start(fs_f));

  vga_timing_fetch #(
    .P_IMAGE_WIDTH(SIW), .P_HFP_WIDTH(SHFP), .P_HSYNCH_WIDTH(SHS), .P_HBP_WIDTH(SHBP),
    .P_IMAGE_HEIGHT(SIH), .P_VFP_HEIGHT(SVFP), .P_VSYNCH_HEIGHT(SVS), .P_VBP_HEIGHT(SVBP)
  ) u_small (
    .clk(clk), .reset(reset), .enable(en_s), .rd_addr(addr_s), .rd_en(ren_s),
    .H_pos(hp_s), .V_pos(vp_s), .valid_video(vv_s), .frame_start(fs_s));

  // Behavioural ROM, latency 2, data = address.
  logic [ADDR_W-1:0] rf1, rf2, rs1, rs2;
  always @(posedge clk) begin
    rf1 <= addr_f; rf2 <= rf1;
    rs1 <= addr_s; rs2 <= rs1;
  end

  typedef struct { int h; int v; bit act; bit fr; } tup_t;

  int iw[2], ih[2], ht[2], vt[2];
  int hpos[2], vpos[2];
  tup_t hq_f[$], hq_s[$];
  int n_tests, n_fail;

  // Current raster point for DUT i, then advance it if enabled.
  function automatic tup_t sample(int i, bit en);
    tup_t t;
    t.h   = hpos[i];
    t.v   = vpos[i];
    t.act = en && (hpos[i] < iw[i]) && (vpos[i] < ih[i]);
    t.fr  = en && (hpos[i] == 0) && (vpos[i] == 0);
    if (en) begin
      hpos[i]++;
      if (hpos[i] == ht[i]) begin
        hpos[i] = 0;
        vpos[i] = (vpos[i] + 1) % vt[i];
      end
    end
    return t;
  endfunction

  function automatic int exp_addr(int i, tup_t t);
    return t.act ? (t.v / 2) * (iw[i] / 2) + t.h / 2 : 0;
  endfunction

  task automatic model_reset();
    tup_t z;
    z.h = 0; z.v = 0; z.act = 0; z.fr = 0;
    for (int i = 0; i < 2; i++) begin hpos[i] = 0; vpos[i] = 0; end
    hq_f.delete(); hq_s.delete();
    for (int k = 0; k < D; k++) begin hq_f.push_back(z); hq_s.push_back(z); end
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    tup_t o, l;
    o = hq_f[0]; l = hq_f[$];
    chk("full", {hp_f, vp_f, vv_f, fs_f, ren_f, 32'(addr_f)},
        {32'(o.h), 32'(o.v), o.act, o.fr, l.act, 32'(exp_addr(0, l))});
    if (o.act) chk("rom_full", 128'(rf2), 128'(exp_addr(0, o)));
    if (l.act && l.h == 1279 && l.v == 0) chk("addr_l0_end", 128'(addr_f), 128'd639);
    if (l.act && l.h == 0 && l.v == 2)    chk("addr_l2_start", 128'(addr_f), 128'd640);
    o = hq_s[0]; l = hq_s[$];
    chk("small", {hp_s, vp_s, vv_s, fs_s, ren_s, 32'(addr_s)},
        {32'(o.h), 32'(o.v), o.act, o.fr, l.act, 32'(exp_addr(1, l))});
    if (o.act) chk("rom_small", 128'(rs2), 128'(exp_addr(1, o)));
    if (l.act && l.h == SIW-1 && l.v == SIH-1)
      chk("addr_small_last", 128'(addr_s), 128'((SIW/2)*(SIH/2) - 1));
  endtask

  initial begin
    int drop_f, drop_s, rst2;
    bit done5, prev_rst;
    iw = '{IMAGE_WIDTH, SIW}; ih = '{IMAGE_HEIGHT, SIH};
    ht = '{H_TOTAL, SIW+SHFP+SHS+SHBP}; vt = '{V_TOTAL, SIH+SVFP+SVS+SVBP};
    n_tests = 0; n_fail = 0;
    drop_f = 0; drop_s = 0; done5 = 0;
    rst2 = $urandom_range(38000, 40000);
    reset = 1'b1; en_f = 1'b1; en_s = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_all();
    prev_rst = 1'b1;
    for (int c = 0; c < N_CYC; c++) begin
      @(negedge clk);
      reset = (c < 1) || (c >= 300 && c < 302) || (c >= rst2 && c < rst2 + 2);
      if (drop_f > 0) begin
        en_f = 1'b0; drop_f--;
      end else if (!done5 && !reset && hpos[0] == 500 && vpos[0] == 10) begin
        done5 = 1; drop_f = 6; en_f = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        drop_f = $urandom_range(0, 7); en_f = 1'b0;
      end else en_f = 1'b1;
      if (drop_s > 0) begin
        en_s = 1'b0; drop_s--;
      end else if ($urandom_range(0, 39) == 0) begin
        drop_s = $urandom_range(0, 5); en_s = 1'b0;
      end else en_s = 1'b1;
      if (reset) model_reset();
      if (reset && !prev_rst) #1 check_all();
      prev_rst = reset;
      @(posedge clk);
      if (!reset) begin
        hq_f.push_back(sample(0, en_f)); void'(hq_f.pop_front());
        hq_s.push_back(sample(1, en_s)); void'(hq_s.pop_front());
      end
      #1 check_all();
      if (n_fail > 20) break;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
